// File: rtl/d_mem_arbiter_if.sv
// Request/response handshake bundle for one requester of the data-memory arbiter.
// The requester side uses the master modport, the arbiter uses the slave modport.
interface d_mem_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_mask;
  logic        req_we;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_mask, req_we, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_mask, req_we, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/d_mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the byte-addressed data
// memory. Port 0 is the CPU load/store unit, port 1 the debug/loader port.
// One access is in flight at a time: IDLE (grant) -> ACCESS (one memory cycle)
// -> RESP (hold the registered response until the winner takes it).
module d_mem_arbiter #(
  parameter int MEMORY_SIZE = 2048
) (
  input  logic                  clk,
  input  logic                  rstn,
  d_mem_arbiter_if.slave        port0,
  d_mem_arbiter_if.slave        port1,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_write_data,
  output logic [1:0]            mem_data_mask,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  input  logic [31:0]           mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_prio;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_mask;
  logic        r_we;
  logic        r_port;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_rsp_err;

  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic        w_rsp_take;

  // Access size in bytes from the mask code; 0 marks the illegal code.
  function automatic logic [2:0] f_size(input logic [1:0] mask);
    case (mask)
      2'b01:   f_size = 3'd1;
      2'b10:   f_size = 3'd2;
      2'b11:   f_size = 3'd4;
      default: f_size = 3'd0;
    endcase
  endfunction

  // Rejects illegal size codes, misaligned halves/words and accesses that run
  // past the end of memory. The end address is formed at 33 bits so an access
  // near 0xFFFFFFFF cannot wrap around and look in range.
  function automatic logic f_err(input logic [31:0] addr, input logic [1:0] mask);
    logic [32:0] w_end;
    w_end = {1'b0, addr} + {30'd0, f_size(mask)};
    f_err = (mask == 2'b00)
          | ((mask == 2'b10) && addr[0])
          | ((mask == 2'b11) && (addr[1:0] != 2'b00))
          | (w_end > 33'(MEMORY_SIZE));
  endfunction

  // Keeps only the bytes belonging to the access size so load data is zero-extended.
  function automatic logic [31:0] f_zext(input logic [31:0] data, input logic [1:0] mask);
    case (mask)
      2'b01:   f_zext = {24'd0, data[7:0]};
      2'b10:   f_zext = {16'd0, data[15:0]};
      2'b11:   f_zext = data;
      default: f_zext = 32'd0;
    endcase
  endfunction

  // Grant selection, next state and all combinational outputs.
  always_comb begin
    w_grant0       = 1'b0;
    w_grant1       = 1'b0;
    w_accept       = 1'b0;
    w_rsp_take     = 1'b0;
    w_next_state   = r_state;
    port0.req_ready = 1'b0;
    port1.req_ready = 1'b0;
    mem_write_en   = 1'b0;
    mem_read_en    = 1'b0;

    case (r_state)
      IDLE: begin
        // r_prio == 0 favours port 0 when both ask in the same cycle.
        if (port0.req_valid && (!port1.req_valid || !r_prio)) begin
          w_grant0 = 1'b1;
        end else if (port1.req_valid) begin
          w_grant1 = 1'b1;
        end
        w_accept        = w_grant0 | w_grant1;
        port0.req_ready = w_grant0;
        port1.req_ready = w_grant1;
        if (w_accept) begin
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        mem_write_en = !r_err && r_we;
        mem_read_en  = !r_err && !r_we;
        w_next_state = RESP;
      end
      RESP: begin
        w_rsp_take = r_port ? port1.rsp_ready : port0.rsp_ready;
        if (w_rsp_take) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // The memory bus always shows the latched request; only the strobes are gated.
  assign mem_addr       = r_addr;
  assign mem_write_data = r_wdata;
  assign mem_data_mask  = r_mask;

  // Response is presented only to the port that won the grant, only in RESP.
  assign port0.rsp_valid = (r_state == RESP) && !r_port;
  assign port1.rsp_valid = (r_state == RESP) && r_port;
  assign port0.rsp_rdata = port0.rsp_valid ? r_rdata : 32'd0;
  assign port1.rsp_rdata = port1.rsp_valid ? r_rdata : 32'd0;
  assign port0.rsp_err   = port0.rsp_valid && r_rsp_err;
  assign port1.rsp_err   = port1.rsp_valid && r_rsp_err;

  // Sequencer state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the winning request and its error verdict on the accept edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_mask  <= 2'b00;
      r_we    <= 1'b0;
      r_port  <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      if (w_grant1) begin
        r_addr  <= port1.req_addr;
        r_wdata <= port1.req_wdata;
        r_mask  <= port1.req_mask;
        r_we    <= port1.req_we;
        r_err   <= f_err(port1.req_addr, port1.req_mask);
      end else begin
        r_addr  <= port0.req_addr;
        r_wdata <= port0.req_wdata;
        r_mask  <= port0.req_mask;
        r_we    <= port0.req_we;
        r_err   <= f_err(port0.req_addr, port0.req_mask);
      end
      r_port <= w_grant1;
    end
  end

  // Capture the response at the end of ACCESS and hand priority to the other port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdata   <= 32'd0;
      r_rsp_err <= 1'b0;
      r_prio    <= 1'b0;
    end else if (r_state == ACCESS) begin
      r_rdata   <= (r_err || r_we) ? 32'd0 : f_zext(mem_read_data, r_mask);
      r_rsp_err <= r_err;
      r_prio    <= !r_port;
    end
  end

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Bench for d_mem_arbiter: transaction-level reference model with a per-cycle
// compare process, queue-driven requesters and a byte-array memory.
module tb_d_mem_arbiter;
  localparam int MS = 2048;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  m;
    logic        we;
  } req_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  d_mem_arbiter_if p0_if ();
  d_mem_arbiter_if p1_if ();

  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic [1:0]  mem_data_mask;
  logic        mem_write_en, mem_read_en;

  d_mem_arbiter #(.MEMORY_SIZE(MS)) dut (
    .clk(clk), .rstn(rstn), .port0(p0_if.slave), .port1(p1_if.slave),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_data_mask(mem_data_mask),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_read_data(mem_read_data)
  );

  // requester-side variables
  logic        tb_v [2];
  logic [31:0] tb_a [2];
  logic [31:0] tb_d [2];
  logic [1:0]  tb_m [2];
  logic        tb_we [2];
  logic        tb_rr [2];
  int          rr_mode [2];
  logic        hs [2];
  req_t        q0 [$];
  req_t        q1 [$];

  assign p0_if.req_valid = tb_v[0];  assign p1_if.req_valid = tb_v[1];
  assign p0_if.req_addr  = tb_a[0];  assign p1_if.req_addr  = tb_a[1];
  assign p0_if.req_wdata = tb_d[0];  assign p1_if.req_wdata = tb_d[1];
  assign p0_if.req_mask  = tb_m[0];  assign p1_if.req_mask  = tb_m[1];
  assign p0_if.req_we    = tb_we[0]; assign p1_if.req_we    = tb_we[1];
  assign p0_if.rsp_ready = tb_rr[0]; assign p1_if.rsp_ready = tb_rr[1];

  logic        w_rdy [2];
  logic        w_rv [2];
  logic [31:0] w_rd [2];
  logic        w_re [2];
  assign w_rdy[0] = p0_if.req_ready; assign w_rdy[1] = p1_if.req_ready;
  assign w_rv[0]  = p0_if.rsp_valid; assign w_rv[1]  = p1_if.rsp_valid;
  assign w_rd[0]  = p0_if.rsp_rdata; assign w_rd[1]  = p1_if.rsp_rdata;
  assign w_re[0]  = p0_if.rsp_err;   assign w_re[1]  = p1_if.rsp_err;

  // physical memory driven by the DUT
  logic [7:0] tb_mem [0:MS-1] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_write_en) begin
      for (int i = 0; i < 4; i++) begin
        if (i < ((mem_data_mask == 2'b11) ? 4 : int'(mem_data_mask)))
          tb_mem[(int'(mem_addr[10:0]) + i) % MS] <= mem_write_data[8*i +: 8];
      end
    end
  end
  always_comb begin
    mem_read_data = 32'd0;
    if (mem_read_en) begin
      for (int i = 0; i < 4; i++) begin
        if (i < ((mem_data_mask == 2'b11) ? 4 : int'(mem_data_mask)))
          mem_read_data[8*i +: 8] = tb_mem[(int'(mem_addr[10:0]) + i) % MS];
      end
    end
  end

  // bookkeeping
  int total = 0;
  int bad = 0;
  int n_rsp [2];
  logic [31:0] last_rd [2];
  logic        last_er [2];
  int grant_log [4096];
  int n_grant = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model (transaction level)
  logic [7:0]  mm [0:MS-1] = '{default: 8'h00};
  int          m_phase;     // 0 idle, 1 memory cycle, 2 response pending
  bit          m_prio, m_port, m_we, m_err;
  logic [31:0] m_a, m_d, m_rd;
  logic [1:0]  m_m;

  function automatic int sz(input logic [1:0] m);
    return (m == 2'd1) ? 1 : (m == 2'd2) ? 2 : (m == 2'd3) ? 4 : 0;
  endfunction

  function automatic bit bad_access(input logic [31:0] a, input logic [1:0] m);
    int s;
    s = sz(m);
    if (s == 0) return 1'b1;
    if ((a % s) != 0) return 1'b1;
    if ({32'd0, a} + 64'(s) > 64'(MS)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] m);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < sz(m); i++) r = r | (32'(mm[a + i]) << (8 * i));
    return r;
  endfunction

  // compare process: checks every cycle, then advances the model across the edge
  always @(negedge clk) begin
    bit g0, g1, ev;
    int p;
    for (int k = 0; k < 2; k++) hs[k] = rstn && tb_v[k] && w_rdy[k];
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin
        chk("reset_req_ready", 32'(w_rdy[k]), 32'd0);
        chk("reset_rsp_valid", 32'(w_rv[k]), 32'd0);
        chk("reset_rsp_rdata", w_rd[k], 32'd0);
        chk("reset_rsp_err", 32'(w_re[k]), 32'd0);
      end
      chk("reset_mem_addr", mem_addr, 32'd0);
      chk("reset_mem_wdata", mem_write_data, 32'd0);
      chk("reset_mem_mask", 32'(mem_data_mask), 32'd0);
      chk("reset_mem_en", {30'd0, mem_write_en, mem_read_en}, 32'd0);
      m_phase = 0; m_prio = 0; m_port = 0; m_we = 0; m_err = 0;
      m_a = 0; m_d = 0; m_m = 0; m_rd = 0;
    end else begin
      g0 = (m_phase == 0) && tb_v[0] && (!tb_v[1] || !m_prio);
      g1 = (m_phase == 0) && tb_v[1] && !g0;
      chk("req0_ready", 32'(w_rdy[0]), 32'(g0));
      chk("req1_ready", 32'(w_rdy[1]), 32'(g1));
      for (int k = 0; k < 2; k++) begin
        ev = (m_phase == 2) && (int'(m_port) == k);
        chk("rsp_valid", 32'(w_rv[k]), 32'(ev));
        if (ev) begin
          chk("rsp_rdata", w_rd[k], m_rd);
          chk("rsp_err", 32'(w_re[k]), 32'(m_err));
        end
        if (w_rv[k] && tb_rr[k]) begin
          last_rd[k] = w_rd[k];
          last_er[k] = w_re[k];
          n_rsp[k]++;
        end
      end
      chk("mem_addr", mem_addr, m_a);
      chk("mem_write_data", mem_write_data, m_d);
      chk("mem_data_mask", 32'(mem_data_mask), 32'(m_m));
      chk("mem_write_en", 32'(mem_write_en), 32'((m_phase == 1) && !m_err && m_we));
      chk("mem_read_en", 32'(mem_read_en), 32'((m_phase == 1) && !m_err && !m_we));
      case (m_phase)
        0: if (g0 || g1) begin
          p = g1 ? 1 : 0;
          m_port = g1; m_a = tb_a[p]; m_d = tb_d[p]; m_m = tb_m[p]; m_we = tb_we[p];
          m_err = bad_access(m_a, m_m);
          m_rd = (m_err || m_we) ? 32'd0 : model_read(m_a, m_m);
          if (n_grant < 4096) grant_log[n_grant] = p;
          n_grant++;
          m_phase = 1;
        end
        1: begin
          if (!m_err && m_we)
            for (int i = 0; i < sz(m_m); i++) mm[m_a + i] = m_d[8*i +: 8];
          m_prio = !m_port;
          m_phase = 2;
        end
        default: if (tb_rr[m_port]) m_phase = 0;
      endcase
    end
  end

  // requesters: present queued requests, drop valid after the accept edge
  initial begin
    req_t r;
    for (int k = 0; k < 2; k++) begin
      tb_v[k] = 0; tb_a[k] = 0; tb_d[k] = 0; tb_m[k] = 0; tb_we[k] = 0; tb_rr[k] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (!rstn || hs[k]) tb_v[k] = 0;
        tb_rr[k] = (rr_mode[k] == 0) ? 1'b1 : (rr_mode[k] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (rstn && !tb_v[0] && q0.size() > 0) begin
        r = q0.pop_front();
        tb_a[0] = r.a; tb_d[0] = r.d; tb_m[0] = r.m; tb_we[0] = r.we; tb_v[0] = 1;
      end
      if (rstn && !tb_v[1] && q1.size() > 0) begin
        r = q1.pop_front();
        tb_a[1] = r.a; tb_d[1] = r.d; tb_m[1] = r.m; tb_we[1] = r.we; tb_v[1] = 1;
      end
    end
  end

  task automatic push(input int p, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] m, input logic we);
    req_t r;
    r.a = a; r.d = d; r.m = m; r.we = we;
    if (p == 0) q0.push_back(r); else q1.push_back(r);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #3;
      if (q0.size() == 0 && q1.size() == 0 && !tb_v[0] && !tb_v[1] && m_phase == 0) break;
    end
    total++;
    if (k == budget) begin
      bad++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, required finish before 80000 cycles");
    $fatal(1);
  end

  initial begin
    int k, n0, n1;
    logic [31:0] d0, a;
    logic [1:0] m;
    n_rsp[0] = 0; n_rsp[1] = 0;
    rr_mode[0] = 0; rr_mode[1] = 0;
    rstn = 0;
    repeat (3) @(posedge clk);

    // contention straight out of reset: both ports hold word loads
    push(0, 32'h0, 0, 2'b11, 0); push(0, 32'h4, 0, 2'b11, 0);
    push(1, 32'h8, 0, 2'b11, 0); push(1, 32'hC, 0, 2'b11, 0);
    #2 rstn = 1;
    wait_idle(200);
    chk("contention_grant0", 32'(grant_log[0]), 32'd0);
    chk("contention_grant1", 32'(grant_log[1]), 32'd1);
    chk("contention_grant2", 32'(grant_log[2]), 32'd0);
    chk("contention_grant3", 32'(grant_log[3]), 32'd1);
    chk("contention_rsp0", 32'(n_rsp[0]), 32'd2);
    chk("contention_rsp1", 32'(n_rsp[1]), 32'd2);

    // single load of bytes 11 22 33 44 at 0x10, with latency check
    push(1, 32'h10, 32'h44332211, 2'b11, 1);
    wait_idle(50);
    push(0, 32'h10, 0, 2'b11, 0);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tb_v[0] && w_rdy[0]) break;
    end
    chk("load_accept_seen", 32'(k < 20), 32'd1);
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (w_rv[0]) break;
    end
    chk("load_latency", 32'(k + 1), 32'd2);
    wait_idle(50);
    chk("load_rdata", last_rd[0], 32'h44332211);
    chk("load_err", 32'(last_er[0]), 32'd0);

    // byte then half store from port 1, word load back
    push(1, 32'h21, 32'h000000AB, 2'b01, 1);
    push(1, 32'h22, 32'h0000BEEF, 2'b10, 1);
    wait_idle(50);
    push(0, 32'h20, 0, 2'b11, 0);
    wait_idle(50);
    chk("byte_half_rdata", last_rd[0], 32'hBEEFAB00);
    push(1, 32'h22, 0, 2'b10, 0);
    wait_idle(50);
    chk("half_load_zext", last_rd[1], 32'h0000BEEF);

    // illegal accesses, alternating ports and load/store
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin a = 32'h1; m = 2'b10; end
        1: begin a = 32'h2; m = 2'b11; end
        2: begin a = 32'h30; m = 2'b00; end
        3: begin a = 32'(MS - 2); m = 2'b11; end
        default: begin a = 32'hFFFFFFFC; m = 2'b11; end
      endcase
      push(i % 2, a, 32'hDEADBEEF, m, 1'(i % 2));
      wait_idle(50);
      chk("err_flag", 32'(last_er[i % 2]), 32'd1);
      chk("err_rdata", last_rd[i % 2], 32'd0);
    end

    // response backpressure on port 0 while port 1 waits
    rr_mode[0] = 2;
    n1 = n_rsp[1];
    push(0, 32'h10, 0, 2'b11, 0);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (w_rv[0]) break;
    end
    chk("bp_rsp_seen", 32'(k < 20), 32'd1);
    push(1, 32'h20, 0, 2'b11, 0);
    d0 = w_rd[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp0_valid", 32'(w_rv[0]), 32'd1);
      chk("bp_rsp0_rdata", w_rd[0], d0);
      chk("bp_req1_ready", 32'(w_rdy[1]), 32'd0);
    end
    rr_mode[0] = 0;
    wait_idle(50);
    chk("bp_rdata0", last_rd[0], 32'h44332211);
    chk("bp_served1", 32'(n_rsp[1] - n1), 32'd1);
    chk("bp_rdata1", last_rd[1], 32'hBEEFAB00);

    // reset during the memory cycle of a store to 0x40
    push(0, 32'h40, 32'h000000A5, 2'b01, 1);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tb_v[0] && w_rdy[0]) break;
    end
    chk("rst_accept_seen", 32'(k < 20), 32'd1);
    @(posedge clk); #2 rstn = 0;
    n0 = n_rsp[0];
    repeat (2) @(posedge clk);
    #2 rstn = 1;
    repeat (5) @(negedge clk);
    chk("rst_mem40", 32'(tb_mem[64]), 32'd0);
    chk("rst_no_rsp", 32'(n_rsp[0]), 32'(n0));

    // randomized traffic with random response backpressure
    rr_mode[0] = 1; rr_mode[1] = 1;
    for (int i = 0; i < 150; i++) begin
      for (int p = 0; p < 2; p++) begin
        k = $urandom_range(0, 9);
        if (k < 7) a = 32'h80 + 32'($urandom_range(0, 63));
        else if (k == 7) a = 32'(MS) - 32'($urandom_range(1, 4));
        else if (k == 8) a = 32'hFFFFFFFF - 32'($urandom_range(0, 7));
        else a = $urandom;
        m = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) begin
          if (m == 2'b10) a[0] = 1'b0;
          if (m == 2'b11) a[1:0] = 2'b00;
        end
        push(p, a, $urandom, m, 1'($urandom_range(0, 1)));
      end
    end
    wait_idle(20000);
    rr_mode[0] = 0; rr_mode[1] = 0;
    repeat (2) @(posedge clk);

    k = 0;
    for (int i = 0; i < MS; i++) if (tb_mem[i] !== mm[i]) k++;
    chk("mem_image_mismatches", 32'(k), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
